count_arb: RTL and testbench

- Controller that shares one counting engine between NREQ requesters.
- Arbitrates pending requests round-robin and latches the winner's target length.
- Sequences the count to completion, then returns a one-cycle done pulse to the owner.
- Sits in front of the count datapath: the datapath observes gnt/cnt/busy; requesters see only gnt and done.

---
 rtl/count_arb_pkg.sv | 21 ++
 rtl/count_arb_if.sv | 38 +++
 rtl/count_arb_rr_pick.sv | 41 ++++
 rtl/count_arb.sv | 155 +++++++++++++++
 tb/tb_count_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_arb_pkg.sv
// ---------------------------------------------------------------------------
// count_pkg
// Shared definitions for the count_arb slice: controller state encoding and
// default sizing for the requester count and counter width.
// ---------------------------------------------------------------------------
package count_pkg;

   // Controller states, binary encoded
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Default number of requesters sharing the engine (legal range 2..8)
   localparam int NREQ_DEF = 4;

   // Default counter / length width in bits
   localparam int CW_DEF = 8;

endpackage : count_pkg

// File: rtl/count_arb_if.sv
// ---------------------------------------------------------------------------
// count_arb_if
// Bundles the requester-side and datapath-side signals of count_arb.
//   req   : request level per requester
//   len   : packed target lengths, requester i at [i*CW +: CW]
//   pause : freezes counting while high
//   gnt   : one-hot owner of the counting engine
//   busy  : engine is occupied by a job
//   cnt   : current count of the active job
//   done  : one-cycle completion pulse to the owner
// Modports: master drives req/len/pause, slave (count_arb) drives the rest.
// ---------------------------------------------------------------------------
interface count_arb_if
   import count_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int CW   = CW_DEF
);

   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] len;
   logic               pause;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic [CW-1:0]      cnt;
   logic [NREQ-1:0]    done;

   modport master (
      output req, len, pause,
      input  gnt, busy, cnt, done
   );

   modport slave (
      input  req, len, pause,
      output gnt, busy, cnt, done
   );

endinterface : count_arb_if

// File: rtl/count_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. The search starts at the
// requester just after 'last' and wraps around, so the most recent owner is
// considered last.
//   req    : request vector
//   last   : index of the previous owner
//   winner : one-hot selected requester (all zero when nothing requests)
//   valid  : at least one request is pending
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int LW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

   logic found;

   // Walk the priority order last+1, last+2, ... and take the first set bit.
   // The inner loop only ever indexes with its own constant loop variable,
   // which keeps the selection free of variable bit indexing.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (((int'(last) + k) % NREQ) == i)) begin
               winner[i] = 1'b1;
               found     = 1'b1;
            end
         end
      end
   end

   assign valid = |req;

endmodule : rr_pick

// File: rtl/count_arb.sv
// ---------------------------------------------------------------------------
// count_arb
// Shares one counting engine between NREQ requesters. Requests are arbitrated
// round-robin while idle; the winner's length is latched and counted from 0
// up to that length, after which the owner receives a one-cycle done pulse.
//   ck   : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : count_arb_if.slave (req/len/pause in, gnt/busy/cnt/done out)
// Optional build macro COUNT_ARB_ABORT_EN: when defined, an owner that drops
// its request during counting abandons the job without a done pulse.
// ---------------------------------------------------------------------------
module count_arb
   import count_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic        ck,
   input  logic        rst,
   count_arb_if.slave  bus
);

   localparam int LW = $clog2(NREQ);

   state_e              state;
   state_e              state_nx;
   logic [NREQ-1:0]     gnt_q;
   logic [CW-1:0]       cnt_q;
   logic [CW-1:0]       len_q;
   logic [LW-1:0]       last_q;
   logic [NREQ-1:0]     pick_oh;
   logic                pick_valid;
   logic [CW-1:0]       pick_len;
   logic [LW-1:0]       owner_idx;
   logic                cnt_last;
`ifdef COUNT_ARB_ABORT_EN
   logic                own_req;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .LW   (LW)
   ) u_pick (
      .req    (bus.req),
      .last   (last_q),
      .winner (pick_oh),
      .valid  (pick_valid)
   );

   // Translate the one-hot winner into its length and the held grant into an
   // owner index, using constant loop indices only.
   always_comb begin
      pick_len  = '0;
      owner_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_oh[i]) begin
            pick_len = bus.len[i*CW +: CW];
         end
         if (gnt_q[i]) begin
            owner_idx = LW'(i);
         end
      end
   end

   // cnt never exceeds len_q while running, so this increment cannot wrap.
   assign cnt_last = ((cnt_q + CW'(1)) == len_q);

`ifdef COUNT_ARB_ABORT_EN
   assign own_req = |(bus.req & gnt_q);
`endif

   // State register
   always_ff @(posedge ck) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic. A zero-length job skips RUN and completes on its
   // first granted cycle.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nx = (pick_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
`ifdef COUNT_ARB_ABORT_EN
            if (!own_req) begin
               state_nx = ST_IDLE;
            end else
`endif
            if (!bus.pause && cnt_last) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Job registers: grant, latched length, count and round-robin pointer.
   // The pointer moves to the owner only when the job leaves the engine, so
   // a requester that stays asserted is served after everyone else pending.
   always_ff @(posedge ck) begin
      if (rst) begin
         gnt_q  <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
         last_q <= LW'(NREQ - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt_q <= pick_oh;
                  len_q <= pick_len;
                  cnt_q <= '0;
               end
            end
            ST_RUN: begin
`ifdef COUNT_ARB_ABORT_EN
               if (!own_req) begin
                  gnt_q  <= '0;
                  last_q <= owner_idx;
               end else
`endif
               if (!bus.pause) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               gnt_q  <= '0;
               last_q <= owner_idx;
            end
            default: begin
               gnt_q <= '0;
            end
         endcase
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.busy = (state == ST_RUN) || (state == ST_DONE);
   assign bus.cnt  = cnt_q;
   assign bus.done = (state == ST_DONE) ? gnt_q : '0;

endmodule : count_arb

// File: tb/tb_count_arb.sv
// ---------------------------------------------------------------------------
// tb_count_arb
// Self-checking bench for count_arb (NREQ=4, CW=8). Directed scenarios check
// against fixed expectations; a randomized run checks every cycle against a
// job-level behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_count_arb;

   localparam int NREQ = 4;
   localparam int CW   = 8;

   typedef logic [16:0] snap_t;

   logic ck  = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   // Job-level model state: owner index (-1 when idle), target, count, pointer
   int m_owner;
   int m_target;
   int m_cnt;
   int m_last;

   always #5 ck = ~ck;

   count_arb_if #(.NREQ(NREQ), .CW(CW)) bus ();

   count_arb #(
      .NREQ (NREQ),
      .CW   (CW)
   ) dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus)
   );

   // Packs an expected output set as {gnt, done, busy, cnt}
   function automatic snap_t mk(input logic [3:0] g, input logic [3:0] d,
                                input logic b, input logic [7:0] c);
      return {g, d, b, c};
   endfunction

   function automatic snap_t observe();
      return {bus.gnt, bus.done, bus.busy, bus.cnt};
   endfunction

   function automatic string show(input snap_t s);
      return $sformatf("gnt=%b done=%b busy=%b cnt=%0d",
                       s[16:13], s[12:9], s[8], s[7:0]);
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      bus.req   = '0;
      bus.len   = '0;
      bus.pause = 1'b0;
      @(negedge ck);
      @(negedge ck);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      snap_t o;
      rst       = 1'b1;
      bus.req   = 4'b1111;
      bus.len   = {8'd3, 8'd3, 8'd3, 8'd3};
      bus.pause = 1'b0;
      @(negedge ck);
      @(negedge ck);
      o = observe();
      n_checks++;
      if (o !== mk(4'b0, 4'b0, 1'b0, 8'd0)) begin
         n_fail++;
         $display("[TB] FAIL reset_values: got %s, want %s", show(o), show(mk(4'b0, 4'b0, 1'b0, 8'd0)));
      end
      bus.req = '0;
      rst     = 1'b0;
   endtask

   task automatic test_single_job();
      snap_t o, e;
      do_reset();
      bus.len = {8'd0, 8'd0, 8'd0, 8'd3};
      bus.req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         @(negedge ck);
         o = observe();
         e = mk(4'b0001, (i == 3) ? 4'b0001 : 4'b0000, 1'b1, 8'(i));
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL single_job cycle %0d: got %s, want %s", i, show(o), show(e));
         end
         if (i == 3) bus.req = '0;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge ck);
         o = observe();
         e = mk(4'b0, 4'b0, 1'b0, 8'd3);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL single_job_idle %0d: got %s, want %s", i, show(o), show(e));
         end
      end
   endtask

   task automatic test_round_robin();
      snap_t o, e;
      logic [3:0] oh;
      do_reset();
      bus.len = {8'd1, 8'd1, 8'd1, 8'd1};
      bus.req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         oh = 4'(1 << (j % NREQ));
         for (int ph = 0; ph < 3; ph++) begin
            @(negedge ck);
            o = observe();
            case (ph)
               0:       e = mk(oh, 4'b0, 1'b1, 8'd0);
               1:       e = mk(oh, oh, 1'b1, 8'd1);
               default: e = mk(4'b0, 4'b0, 1'b0, 8'd1);
            endcase
            n_checks++;
            if (o !== e) begin
               n_fail++;
               $display("[TB] FAIL round_robin job %0d phase %0d: got %s, want %s", j, ph, show(o), show(e));
            end
            if (j == 4 && ph == 1) bus.req = '0;
         end
      end
   endtask

   task automatic test_zero_len();
      snap_t o, e;
      bus.len = {8'd9, 8'd0, 8'd7, 8'd5};
      bus.req = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         o = observe();
         e = (i == 0) ? mk(4'b0100, 4'b0100, 1'b1, 8'd0) : mk(4'b0, 4'b0, 1'b0, 8'd0);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL zero_len cycle %0d: got %s, want %s", i, show(o), show(e));
         end
         bus.req = '0;
      end
   endtask

   task automatic test_pause();
      snap_t o, e;
      int ec[9];
      ec = '{0, 1, 2, 2, 2, 2, 3, 4, 5};
      do_reset();
      bus.len = {8'd0, 8'd0, 8'd0, 8'd5};
      bus.req = 4'b0001;
      for (int i = 0; i < 9; i++) begin
         @(negedge ck);
         o = observe();
         e = mk(4'b0001, (i == 8) ? 4'b0001 : 4'b0000, 1'b1, 8'(ec[i]));
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL pause cycle %0d: got %s, want %s", i, show(o), show(e));
         end
         bus.pause = (i >= 2 && i <= 4);
         if (i == 8) bus.req = '0;
      end
      @(negedge ck);
      o = observe();
      n_checks++;
      if (o !== mk(4'b0, 4'b0, 1'b0, 8'd5)) begin
         n_fail++;
         $display("[TB] FAIL pause_end: got %s, want %s", show(o), show(mk(4'b0, 4'b0, 1'b0, 8'd5)));
      end
   endtask

   task automatic test_max_len();
      snap_t o, e;
      do_reset();
      bus.len = {8'd0, 8'd0, 8'd0, 8'd255};
      bus.req = 4'b0001;
      for (int i = 0; i < 257; i++) begin
         @(negedge ck);
         o = observe();
         if (i < 256) e = mk(4'b0001, (i == 255) ? 4'b0001 : 4'b0000, 1'b1, 8'(i));
         else         e = mk(4'b0, 4'b0, 1'b0, 8'd255);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL max_len cycle %0d: got %s, want %s", i, show(o), show(e));
         end
         if (i == 255) bus.req = '0;
      end
   endtask

   task automatic test_reset_mid_job();
      snap_t o, e;
      do_reset();
      bus.len = {8'd0, 8'd0, 8'd0, 8'd6};
      bus.req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         o = observe();
         e = mk(4'b0001, 4'b0, 1'b1, 8'(i));
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL reset_mid cycle %0d: got %s, want %s", i, show(o), show(e));
         end
      end
      rst = 1'b1;
      @(negedge ck);
      o = observe();
      n_checks++;
      if (o !== mk(4'b0, 4'b0, 1'b0, 8'd0)) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_clear: got %s, want %s", show(o), show(mk(4'b0, 4'b0, 1'b0, 8'd0)));
      end
      rst     = 1'b0;
      bus.len = {8'd4, 8'd3, 8'd0, 8'd6};
      bus.req = 4'b1010;
      for (int i = 0; i < 2; i++) begin
         @(negedge ck);
         o = observe();
         e = (i == 0) ? mk(4'b0010, 4'b0010, 1'b1, 8'd0) : mk(4'b0, 4'b0, 1'b0, 8'd0);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_regrant cycle %0d: got %s, want %s", i, show(o), show(e));
         end
         bus.req = '0;
      end
   endtask

   task automatic test_abort();
      snap_t o, e;
      do_reset();
      bus.len = {8'd0, 8'd0, 8'd0, 8'd4};
      bus.req = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         @(negedge ck);
         o = observe();
         e = mk(4'b0001, 4'b0, 1'b1, 8'(i));
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL abort_start cycle %0d: got %s, want %s", i, show(o), show(e));
         end
      end
      bus.req = '0;
`ifdef COUNT_ARB_ABORT_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         o = observe();
         e = mk(4'b0, 4'b0, 1'b0, 8'd1);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL abort_dropped %0d: got %s, want %s", i, show(o), show(e));
         end
      end
`else
      for (int i = 2; i < 6; i++) begin
         @(negedge ck);
         o = observe();
         if (i < 5) e = mk(4'b0001, (i == 4) ? 4'b0001 : 4'b0000, 1'b1, 8'(i));
         else       e = mk(4'b0, 4'b0, 1'b0, 8'd4);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL no_abort cycle %0d: got %s, want %s", i, show(o), show(e));
         end
      end
`endif
   endtask

   // Advances the job-level model by one rising edge given the inputs seen there
   task automatic model_step(input logic [3:0] r, input logic [31:0] l, input logic p);
      bit picked;
      int w;
      if (m_owner < 0) begin
         picked = 0;
         for (int k = 1; k <= NREQ; k++) begin
            w = (m_last + k) % NREQ;
            if (!picked && r[w]) begin
               picked   = 1;
               m_owner  = w;
               m_target = int'(l[w*CW +: CW]);
               m_cnt    = 0;
            end
         end
      end else if (m_cnt == m_target) begin
         m_last  = m_owner;
         m_owner = -1;
`ifdef COUNT_ARB_ABORT_EN
      end else if (!r[m_owner]) begin
         m_last  = m_owner;
         m_owner = -1;
`endif
      end else if (!p) begin
         m_cnt = m_cnt + 1;
      end
   endtask

   task automatic test_random();
      snap_t o, e;
      logic [3:0]  r;
      logic [31:0] l;
      logic        p;
      logic [3:0]  g;
      do_reset();
      m_owner  = -1;
      m_target = 0;
      m_cnt    = 0;
      m_last   = NREQ - 1;
      for (int c = 0; c < 600; c++) begin
         o = observe();
         g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
         e = mk(g, (m_owner >= 0 && m_cnt == m_target) ? g : 4'b0,
                m_owner >= 0, 8'(m_cnt));
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL random cycle %0d: got %s, want %s", c, show(o), show(e));
         end
         r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) r = '0;
         if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
         for (int k = 0; k < NREQ; k++) l[k*CW +: CW] = 8'($urandom_range(0, 6));
         p = ($urandom_range(0, 3) == 0);
         bus.req   = r;
         bus.len   = l;
         bus.pause = p;
         model_step(r, l, p);
         @(negedge ck);
      end
      bus.req   = '0;
      bus.pause = 1'b0;
   endtask

   initial begin
      bus.req   = '0;
      bus.len   = '0;
      bus.pause = 1'b0;
      test_reset();
      test_single_job();
      test_round_robin();
      test_zero_len();
      test_pause();
      test_max_len();
      test_reset_mid_job();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Bounds the run in case the design stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

endmodule : tb_count_arb
